reg_transfer_sequencer: RTL and testbench

// - Sequences one register-transfer micro-op at a time over the shared register bank.
// - Each register has a latch input (c) and drives the two tri-stated operand buses A and B.
// - Takes a command (src_a, src_b, dst) over a valid/ready handshake and drives the bus enables and latch strobes.
// - Drives one-hot oe_a/oe_b to the per-register bath_a/bath_b inputs, and one-hot latch to the per-register latch inputs.
// - Guarantees at most one driver per bus and holds the operands stable for a fixed execute latency.
// - Writes the result back into dst.

---
 rtl/reg_transfer_sequencer.sv | 124 ++++++++++++
 tb/tb_reg_transfer_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_transfer_sequencer.sv
// Register-transfer sequencer: drives one-hot bus enables for EXEC_LAT+1 cycles, then one latch strobe, then pulses done.
// Latency EXEC_LAT+2 cycles per command; cmd_ready only in IDLE, so commands are never queued.
module reg_transfer_sequencer #(
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 3,
   parameter int EXEC_LAT = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [ADDR_W-1:0]   cmd_src_a,
   input  logic [ADDR_W-1:0]   cmd_src_b,
   input  logic                cmd_use_b,
   input  logic [ADDR_W-1:0]   cmd_dst,
   input  logic                cmd_wr_en,
   output logic [NUM_REGS-1:0] oe_a,
   output logic [NUM_REGS-1:0] oe_b,
   output logic [NUM_REGS-1:0] latch,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam int CNT_W = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(EXEC_LAT - 1);
   localparam logic [ADDR_W:0]   NREGS    = (ADDR_W + 1)'(NUM_REGS);

   typedef enum logic [1:0] {IDLE, DRIVE, WRITE} state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [NUM_REGS-1:0] oe_a_nxt, oe_b_nxt, latch_nxt;
   logic [NUM_REGS-1:0] pend, pend_nxt;
   logic                done_nxt, err_nxt;
   logic                accept, bad_idx;

   function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] idx);
      onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
   endfunction

   assign cmd_ready = (state == IDLE);
   assign accept    = cmd_valid && cmd_ready;

   // Only indices the command actually uses can make it illegal.
   assign bad_idx = ({1'b0, cmd_src_a} >= NREGS)
                 || (cmd_use_b && ({1'b0, cmd_src_b} >= NREGS))
                 || (cmd_wr_en && ({1'b0, cmd_dst} >= NREGS));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      oe_a_nxt  = oe_a;
      oe_b_nxt  = oe_b;
      latch_nxt = '0;
      pend_nxt  = pend;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            oe_a_nxt = '0;
            oe_b_nxt = '0;
            if (accept) begin
               if (bad_idx) begin
                  err_nxt = 1'b1;
               end else begin
                  state_nxt = DRIVE;
                  cnt_nxt   = CNT_LOAD;
                  oe_a_nxt  = onehot(cmd_src_a);
                  oe_b_nxt  = cmd_use_b ? onehot(cmd_src_b) : '0;
                  pend_nxt  = cmd_wr_en ? onehot(cmd_dst) : '0;
               end
            end
         end
         DRIVE: begin
            if (cnt == '0) begin
               state_nxt = WRITE;
               latch_nxt = pend;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         WRITE: begin
            // Buses stay driven through WRITE so c is valid while the latch strobe is high.
            state_nxt = IDLE;
            oe_a_nxt  = '0;
            oe_b_nxt  = '0;
            pend_nxt  = '0;
            done_nxt  = 1'b1;
         end
         default: begin
            state_nxt = IDLE;
            oe_a_nxt  = '0;
            oe_b_nxt  = '0;
            pend_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         oe_a  <= '0;
         oe_b  <= '0;
         latch <= '0;
         pend  <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         oe_a  <= oe_a_nxt;
         oe_b  <= oe_b_nxt;
         latch <= latch_nxt;
         pend  <= pend_nxt;
         busy  <= (state_nxt != IDLE);
         done  <= done_nxt;
         err   <= err_nxt;
      end
   end

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// Bench for reg_transfer_sequencer: scoreboarded per-cycle outputs plus a behavioural register bank on the buses.
module tb_reg_transfer_sequencer;

   localparam int LAT = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_valid6;
   logic [2:0] cmd_src_a, cmd_src_b, cmd_dst;
   logic       cmd_use_b, cmd_wr_en;

   logic       cmd_ready, busy, done, err;
   logic [7:0] oe_a, oe_b, latch;
   logic       cmd_ready6, busy6, done6, err6;
   logic [5:0] oe_a6, oe_b6, latch6;

   always #5 clk = ~clk;

   reg_transfer_sequencer #(.NUM_REGS(8), .ADDR_W(3), .EXEC_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_use_b(cmd_use_b),
      .cmd_dst(cmd_dst), .cmd_wr_en(cmd_wr_en), .oe_a(oe_a), .oe_b(oe_b),
      .latch(latch), .busy(busy), .done(done), .err(err));

   reg_transfer_sequencer #(.NUM_REGS(6), .ADDR_W(3), .EXEC_LAT(LAT)) dut6 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid6), .cmd_ready(cmd_ready6),
      .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_use_b(cmd_use_b),
      .cmd_dst(cmd_dst), .cmd_wr_en(cmd_wr_en), .oe_a(oe_a6), .oe_b(oe_b6),
      .latch(latch6), .busy(busy6), .done(done6), .err(err6));

   typedef struct packed {
      logic [7:0] oe_a;
      logic [7:0] oe_b;
      logic [7:0] latch;
      logic       busy;
      logic       done;
      logic       err;
   } obs_t;

   obs_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   logic onehot_bad = 1'b0;

   // Register bank: each register drives bus A/B when enabled; ALU result c = A + B.
   logic [7:0] bank [8];
   logic [7:0] bus_a, bus_b, c_val;
   logic       bank_load;

   always_comb begin
      bus_a = '0;
      bus_b = '0;
      for (int i = 0; i < 8; i++) begin
         if (oe_a[i]) bus_a = bus_a | bank[i];
         if (oe_b[i]) bus_b = bus_b | bank[i];
      end
   end
   assign c_val = bus_a + bus_b;

   always @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (bank_load)     bank[i] <= 8'(i * 16 + 1);
         else if (latch[i]) bank[i] <= c_val;
      end
   end

   always @(negedge clk) begin
      if (rst_n && (($countones(oe_a) > 1) || ($countones(oe_b) > 1) || ($countones(latch) > 1)))
         onehot_bad = 1'b1;
   end

   function automatic logic [7:0] oh8(input logic [2:0] i);
      oh8 = 8'd1 << i;
   endfunction

   task automatic push_expect(input logic [2:0] a, input logic [2:0] b, input logic ub,
                              input logic [2:0] d, input logic we);
      obs_t e;
      for (int k = 1; k <= LAT + 2; k++) begin
         e.oe_a  = (k <= LAT + 1) ? oh8(a) : 8'h00;
         e.oe_b  = (k <= LAT + 1 && ub) ? oh8(b) : 8'h00;
         e.latch = (k == LAT + 1 && we) ? oh8(d) : 8'h00;
         e.busy  = (k <= LAT + 1);
         e.done  = (k == LAT + 2);
         e.err   = 1'b0;
         exp_q.push_back(e);
      end
   endtask

   task automatic drive_cmd(input logic [2:0] a, input logic [2:0] b, input logic ub,
                            input logic [2:0] d, input logic we);
      cmd_src_a = a; cmd_src_b = b; cmd_use_b = ub; cmd_dst = d; cmd_wr_en = we;
      cmd_valid = 1'b1;
   endtask

   task automatic test_reset();
      obs_t obs;
      @(negedge clk);
      obs = {oe_a, oe_b, latch, busy, done, err};
      checks++;
      if (obs !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%h want=0", obs);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready got ready=%b busy=%b want ready=1 busy=0", cmd_ready, busy);
      end
      drive_cmd(3'd2, 3'd0, 1'b0, 3'd6, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (oe_a !== 8'h04 || busy !== 1'b1) begin
         failures++;
         $display("FAIL reset_pre_drive got oe_a=%h busy=%b want oe_a=04 busy=1", oe_a, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (oe_a !== 8'h00 || oe_b !== 8'h00 || latch !== 8'h00 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_drive got oe_a=%h oe_b=%h latch=%h busy=%b want all 0",
                  oe_a, oe_b, latch, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready got=%b want=1", cmd_ready);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (bank[6] !== 8'h61) begin
         failures++;
         $display("FAIL reset_cancel_write got r6=%h want=61", bank[6]);
      end
   endtask

   task automatic test_basic();
      obs_t obs, e;
      @(negedge clk);
      drive_cmd(3'd1, 3'd3, 1'b1, 3'd5, 1'b1);
      push_expect(3'd1, 3'd3, 1'b1, 3'd5, 1'b1);
      for (int k = 1; k <= LAT + 2; k++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         e = exp_q.pop_front();
         obs = {oe_a, oe_b, latch, busy, done, err};
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL basic_cycle%0d got=%h want=%h", k, obs, e);
         end
      end
      checks++;
      if (bank[5] !== 8'h42) begin
         failures++;
         $display("FAIL basic_writeback got r5=%h want=42", bank[5]);
      end
   endtask

   task automatic test_back_to_back();
      obs_t obs, e;
      @(negedge clk);
      drive_cmd(3'd2, 3'd4, 1'b1, 3'd5, 1'b1);
      push_expect(3'd2, 3'd4, 1'b1, 3'd5, 1'b1);
      for (int k = 1; k <= LAT + 2; k++) begin
         @(negedge clk);
         if (k == 1) drive_cmd(3'd5, 3'd7, 1'b0, 3'd0, 1'b1);
         e = exp_q.pop_front();
         obs = {oe_a, oe_b, latch, busy, done, err};
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL b2b_cmd1_cycle%0d got=%h want=%h", k, obs, e);
         end
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_ready_in_done got=%b want=1", cmd_ready);
      end
      push_expect(3'd5, 3'd7, 1'b0, 3'd0, 1'b1);
      for (int k = 1; k <= LAT + 2; k++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         e = exp_q.pop_front();
         obs = {oe_a, oe_b, latch, busy, done, err};
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL b2b_cmd2_cycle%0d got=%h want=%h", k, obs, e);
         end
         if (k == 1) begin
            checks++;
            if (bus_a !== 8'h62) begin
               failures++;
               $display("FAIL b2b_read_after_write got bus_a=%h want=62", bus_a);
            end
         end
      end
      checks++;
      if (bank[0] !== 8'h62) begin
         failures++;
         $display("FAIL b2b_writeback got r0=%h want=62", bank[0]);
      end
   endtask

   task automatic test_bad_index();
      logic [2:0] tv_a [5]  = '{3'd1, 3'd6, 3'd0, 3'd5, 3'd0};
      logic [2:0] tv_b [5]  = '{3'd0, 3'd0, 3'd6, 3'd7, 3'd0};
      logic       tv_ub[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [2:0] tv_d [5]  = '{3'd7, 3'd0, 3'd0, 3'd7, 3'd5};
      logic       tv_we[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic       tv_err[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [7:0] oh;
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         cmd_src_a = tv_a[t]; cmd_src_b = tv_b[t]; cmd_use_b = tv_ub[t];
         cmd_dst = tv_d[t]; cmd_wr_en = tv_we[t];
         cmd_valid6 = 1'b1;
         @(negedge clk);
         cmd_valid6 = 1'b0;
         oh = oh8(tv_a[t]);
         checks++;
         if (tv_err[t]) begin
            if (err6 !== 1'b1 || oe_a6 !== 6'h00 || oe_b6 !== 6'h00 || latch6 !== 6'h00 || busy6 !== 1'b0) begin
               failures++;
               $display("FAIL bad_idx%0d got err=%b oe_a=%h oe_b=%h latch=%h busy=%b want err=1 rest 0",
                        t, err6, oe_a6, oe_b6, latch6, busy6);
            end
            @(negedge clk);
            checks++;
            if (err6 !== 1'b0 || cmd_ready6 !== 1'b1) begin
               failures++;
               $display("FAIL bad_idx%0d_after got err=%b ready=%b want err=0 ready=1", t, err6, cmd_ready6);
            end
         end else begin
            if (err6 !== 1'b0 || busy6 !== 1'b1 || oe_a6 !== oh[5:0] || oe_b6 !== 6'h00) begin
               failures++;
               $display("FAIL good_idx%0d got err=%b busy=%b oe_a=%h oe_b=%h want err=0 busy=1 oe_a=%h oe_b=0",
                        t, err6, busy6, oe_a6, oe_b6, oh[5:0]);
            end
            repeat (LAT + 1) @(negedge clk);
            checks++;
            if (done6 !== 1'b1) begin
               failures++;
               $display("FAIL good_idx%0d_done got=%b want=1", t, done6);
            end
         end
      end
   endtask

   task automatic test_no_b_no_wr();
      obs_t obs, e;
      @(negedge clk);
      drive_cmd(3'd4, 3'd6, 1'b0, 3'd3, 1'b0);
      push_expect(3'd4, 3'd6, 1'b0, 3'd3, 1'b0);
      for (int k = 1; k <= LAT + 2; k++) begin
         @(negedge clk);
         // A different command held while busy must be ignored.
         if (k == 1) drive_cmd(3'd7, 3'd7, 1'b1, 3'd7, 1'b1);
         if (k == LAT + 1) cmd_valid = 1'b0;
         e = exp_q.pop_front();
         obs = {oe_a, oe_b, latch, busy, done, err};
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL nob_nowr_cycle%0d got=%h want=%h", k, obs, e);
         end
      end
      checks++;
      if (bank[3] !== 8'h31) begin
         failures++;
         $display("FAIL nowr_untouched got r3=%h want=31", bank[3]);
      end
   endtask

   task automatic test_self_op();
      obs_t obs, e;
      @(negedge clk);
      drive_cmd(3'd2, 3'd2, 1'b1, 3'd2, 1'b1);
      push_expect(3'd2, 3'd2, 1'b1, 3'd2, 1'b1);
      for (int k = 1; k <= LAT + 2; k++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         e = exp_q.pop_front();
         obs = {oe_a, oe_b, latch, busy, done, err};
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL self_op_cycle%0d got=%h want=%h", k, obs, e);
         end
      end
      checks++;
      if (bank[2] !== 8'h42) begin
         failures++;
         $display("FAIL self_op_writeback got r2=%h want=42", bank[2]);
      end
      checks++;
      if (onehot_bad !== 1'b0) begin
         failures++;
         $display("FAIL onehot_buses got violation=%b want=0", onehot_bad);
      end
   endtask

   initial begin
      rst_n = 1'b1;
      bank_load = 1'b1;
      cmd_valid = 1'b0;
      cmd_valid6 = 1'b0;
      cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0;
      cmd_use_b = 1'b0; cmd_wr_en = 1'b0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 bank_load = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_bad_index();
      test_no_b_no_wr();
      test_self_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
